baccarat_table_ctrl: RTL and testbench
======================================

Name: baccarat_table_ctrl

Overview:
Parametrised baccarat dealing controller. Deals to NUM_PLAYERS player hands plus one banker hand, and applies the natural and third-card rules per hand. Reports a score for every hand and a win/lose flag pair for each player-versus-banker comparison. Sits between the card-dealer block and the HEX/LEDR display datapath, replacing the fixed one-player sequencer.

Parameters:
NUM_PLAYERS, 2, number of player hands (legal range 1..4).
AUTO_PERIOD, 4, cycles between internal steps; used only when BACCARAT_AUTO_DEAL_EN is defined.

Ports:
clk  in  1  system clock; everything is rising-edge.
reset  in  1  synchronous, active-high reset.
step  in  1  advance request; one advance per cycle sampled high; upstream supplies one-cycle pulses.
new_card  in  4  card rank from the dealer, 1..13.
card_req  out  1  high for one cycle when a card is consumed (step & dealing state).
load_pcard  out  NUM_PLAYERS*3  one-hot deal strobe; bit i*3+k = player i, card k+1.
load_dcard  out  3  one-hot banker deal strobe, cards 1..3.
pscore  out  NUM_PLAYERS*4  player i score in bits [i*4+3:i*4].
dscore  out  4  banker score.
pwin  out  NUM_PLAYERS  player i score >= banker score; valid only when done.
dwin  out  NUM_PLAYERS  banker score >= player i score; valid only when done.
done  out  1  round complete.

Behaviour:
- Card value: ranks 1..9 take their face value; 10..13, 0 and 14..15 count as 0. The raw rank is stored in a 4-bit register per card slot.
- Score: (sum of the hand's card values) mod 10. Use a 5-bit internal sum (maximum 27). Scores are combinational from the card registers, so they are valid the cycle after the capturing edge.
- Load strobes are Moore-style: at most one bit is high across load_pcard and load_dcard, and it marks the pending slot.
- Capture: on a clk edge with step=1, the pending slot latches new_card, card_req is high that cycle, and the FSM advances.
- Deal order:
  - P0c1..P(N-1)c1, then Dc1.
  - P0c2..P(N-1)c2, then Dc2.
  - Each deal state consumes one step.
- EVAL state (one cycle, no step needed):
  - Banker natural (dscore 8 or 9) -> DONE.
  - Otherwise mark player i to draw if its two-card score is 0..5. A player with a natural (8/9) or score 6/7 stands.
- P3 states: visit only the players marked to draw, in ascending index order, one step each.
- Banker third-card decision uses the lead hand, player 0:
  - If player 0 did not draw: banker draws on 0..5.
  - If player 0 drew, with p3 = value of player 0's third card:
    - banker 0..2 draws;
    - banker 3 draws unless p3=8;
    - banker 4 draws on p3 2..7;
    - banker 5 draws on p3 4..7;
    - banker 6 draws on p3 6..7;
    - banker 7 stands.
- D3 state consumes one step, then goes to DONE.
- DONE:
  - done=1; pwin/dwin computed per player.
  - On a tie both pwin[i] and dwin[i] are 1.
  - All load strobes are 0 and card_req is 0.
  - step is ignored; the FSM holds until reset.
- Outside DONE: pwin=0, dwin=0, done=0.
- Reset:
  - State = P0c1, so load_pcard[0]=1 and all other strobes are 0.
  - All card registers, scores, draw flags, pwin, dwin and done are 0.
  - Reset has priority over step on the same edge; reset mid-round aborts the round immediately.
- Strobe width: unused strobe bits are always 0. With NUM_PLAYERS=1 the block is functionally identical to the original one-player sequencer.

Optional Feature:
BACCARAT_AUTO_DEAL_EN
- Defined:
  - An internal counter generates a one-cycle tick every AUTO_PERIOD cycles; the effective step is step | tick.
  - The counter clears on reset and halts in DONE.
  - First tick occurs AUTO_PERIOD cycles after reset deasserts.
- Undefined: no counter; only the step input advances the FSM and AUTO_PERIOD is unused.

Test Plan:
All scenarios use NUM_PLAYERS=2 and the macro undefined unless stated.
1. Reset: hold reset 1 cycle -> load_pcard=6'b000001, load_dcard=0, pscore=0, dscore=0, pwin=0, dwin=0, done=0.
2. Player natural, others draw:
   - Stimulus: cards P0 4,5; P1 2,1; D 3,2, then P1c3=13, Dc3=1.
   - Required: P0 9 stands; P1 3 draws; banker 5 draws. 8 steps total.
   - Final: pscore={4'd3,4'd9}, dscore=6, pwin=2'b01, dwin=2'b10, done=1.
3. Banker natural:
   - Stimulus: P0 3,3; P1 9,9; D 4,4.
   - Required: done=1 after 6 steps plus the EVAL cycle; no third-card strobe ever asserts.
   - Final: pwin=2'b10, dwin=2'b11 (P1 ties at 8).
4. Banker table rule:
   - Stimulus: P0 2,2 then P0c3=8; P1 10,8 (natural); D 1,2.
   - Required: banker 3 with p3=8 stands; load_dcard[2] never high; 7 steps.
   - Final: pscore={4'd8,4'd2}, dscore=3, pwin=2'b10, dwin=2'b01.
5. Reset mid-deal:
   - Stimulus: after 3 steps, assert reset with step=1.
   - Required: next cycle load_pcard[0]=1; all card registers and scores are 0; the step on that edge is not consumed.
6. Done hold plus auto-deal:
   - Stimulus: after DONE, pulse step 5 times.
   - Required: no output changes and card_req=0.
   - Then recompile with BACCARAT_AUTO_DEAL_EN and AUTO_PERIOD=4, step tied 0: first card_req 4 cycles after reset, one every 4 cycles thereafter.

Source files
------------

// File: rtl/baccarat_table_if.sv
// baccarat_table_if: handshake/data bundle between the dealer, the table controller and the display path.
interface baccarat_table_if #(
  parameter int unsigned NUM_PLAYERS = 2
);
  logic                     step;
  logic [3:0]               new_card;
  logic                     card_req;
  logic [NUM_PLAYERS*3-1:0] load_pcard;
  logic [2:0]               load_dcard;
  logic [NUM_PLAYERS*4-1:0] pscore;
  logic [3:0]               dscore;
  logic [NUM_PLAYERS-1:0]   pwin;
  logic [NUM_PLAYERS-1:0]   dwin;
  logic                     done;

  modport master (
    output step, new_card,
    input  card_req, load_pcard, load_dcard, pscore, dscore, pwin, dwin, done
  );

  modport slave (
    input  step, new_card,
    output card_req, load_pcard, load_dcard, pscore, dscore, pwin, dwin, done
  );
endinterface

// File: rtl/baccarat_table_ctrl.sv
// baccarat_table_ctrl: multi-player baccarat dealer with natural and third-card rules.
// Optional macro BACCARAT_AUTO_DEAL_EN adds an internal step tick every AUTO_PERIOD cycles.
module baccarat_table_ctrl #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned AUTO_PERIOD = 4
) (
  input  logic            clk,
  input  logic            reset,
  baccarat_table_if.slave bus
);
  localparam int unsigned NP = NUM_PLAYERS;

  typedef enum logic [2:0] {
    ST_P1, ST_D1, ST_P2, ST_D2, ST_EVAL, ST_P3, ST_D3, ST_DONE
  } state_t;

  state_t          state, state_n;
  logic [1:0]      pidx, pidx_n;
  logic [3:0]      pcard [NP][3];
  logic [3:0]      dcard [3];
  logic [NP-1:0]   draw;
  logic [NP*3-1:0] pstb, pstb_n;
  logic [2:0]      dstb, dstb_n;
  logic            done_q;
  logic            adv;
  logic            dealing;
  logic [3:0]      psc [NP];
  logic [3:0]      dsc;
  logic [NP-1:0]   draw_now;
  logic            first_hit, next_hit;
  logic [1:0]      first_idx, next_idx;
  logic [4:0]      p3;

  function automatic logic [4:0] card_val(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd9) ? {1'b0, r} : 5'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] s;
    s = card_val(a) + card_val(b) + card_val(c);
    if (s >= 5'd20)      s = s - 5'd20;
    else if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  // Banker third-card rule keyed on the lead hand (player 0).
  function automatic logic bank_draw(input logic [3:0] b, input logic p0drew,
                                     input logic [4:0] v);
    if (!p0drew) return b <= 4'd5;
    case (b)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return v != 5'd8;
      4'd4:             return v >= 5'd2 && v <= 5'd7;
      4'd5:             return v >= 5'd4 && v <= 5'd7;
      4'd6:             return v >= 5'd6 && v <= 5'd7;
      default:          return 1'b0;
    endcase
  endfunction

`ifdef BACCARAT_AUTO_DEAL_EN
  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = 32'(tick_cnt) == AUTO_PERIOD - 1;

  always_ff @(posedge clk) begin
    if (reset)                 tick_cnt <= '0;
    else if (state != ST_DONE) tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
  end

  assign adv = bus.step | tick;
`else
  logic unused_period;
  assign unused_period = ^AUTO_PERIOD;
  assign adv = bus.step;
`endif

  assign dealing = (state != ST_EVAL) && (state != ST_DONE);

  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      psc[i]      = hand_score(pcard[i][0], pcard[i][1], pcard[i][2]);
      draw_now[i] = psc[i] <= 4'd5;
    end
    dsc = hand_score(dcard[0], dcard[1], dcard[2]);
  end

  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (!first_hit && draw_now[i]) begin
        first_hit = 1'b1;
        first_idx = 2'(i);
      end
      if (!next_hit && draw[i] && i > 32'(pidx)) begin
        next_hit = 1'b1;
        next_idx = 2'(i);
      end
    end
  end

  // Player 0's third card may be latching on the same edge the banker decides.
  assign p3 = (pidx == 2'd0) ? card_val(bus.new_card) : card_val(pcard[0][2]);

  always_comb begin
    state_n = state;
    pidx_n  = pidx;
    case (state)
      ST_P1: if (adv) begin
        if (32'(pidx) == NP - 1) begin
          state_n = ST_D1;
          pidx_n  = '0;
        end else begin
          pidx_n = pidx + 2'd1;
        end
      end
      ST_D1: if (adv) state_n = ST_P2;
      ST_P2: if (adv) begin
        if (32'(pidx) == NP - 1) begin
          state_n = ST_D2;
          pidx_n  = '0;
        end else begin
          pidx_n = pidx + 2'd1;
        end
      end
      ST_D2: if (adv) state_n = ST_EVAL;
      ST_EVAL: begin
        if (dsc >= 4'd8) begin
          state_n = ST_DONE;
        end else if (first_hit) begin
          state_n = ST_P3;
          pidx_n  = first_idx;
        end else begin
          state_n = bank_draw(dsc, 1'b0, p3) ? ST_D3 : ST_DONE;
        end
      end
      ST_P3: if (adv) begin
        if (next_hit) begin
          pidx_n = next_idx;
        end else begin
          pidx_n  = '0;
          state_n = bank_draw(dsc, draw[0], p3) ? ST_D3 : ST_DONE;
        end
      end
      ST_D3: if (adv) state_n = ST_DONE;
      default: ;
    endcase
  end

  always_comb begin
    pstb_n = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (32'(pidx_n) == i)
        pstb_n[i*3 +: 3] = {state_n == ST_P3, state_n == ST_P2, state_n == ST_P1};
    end
    dstb_n = {state_n == ST_D3, state_n == ST_D2, state_n == ST_D1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_P1;
      pidx   <= '0;
      pstb   <= {{(NP*3-1){1'b0}}, 1'b1};
      dstb   <= '0;
      draw   <= '0;
      done_q <= 1'b0;
      for (int unsigned i = 0; i < NP; i++)
        for (int unsigned k = 0; k < 3; k++)
          pcard[i][k] <= '0;
      for (int unsigned k = 0; k < 3; k++)
        dcard[k] <= '0;
    end else begin
      state  <= state_n;
      pidx   <= pidx_n;
      pstb   <= pstb_n;
      dstb   <= dstb_n;
      done_q <= state_n == ST_DONE;
      if (state == ST_EVAL && dsc < 4'd8)
        draw <= draw_now;
      if (adv) begin
        for (int unsigned i = 0; i < NP; i++) begin
          if (32'(pidx) == i) begin
            if (state == ST_P1) pcard[i][0] <= bus.new_card;
            if (state == ST_P2) pcard[i][1] <= bus.new_card;
            if (state == ST_P3) pcard[i][2] <= bus.new_card;
          end
        end
        if (state == ST_D1) dcard[0] <= bus.new_card;
        if (state == ST_D2) dcard[1] <= bus.new_card;
        if (state == ST_D3) dcard[2] <= bus.new_card;
      end
    end
  end

  always_comb begin
    bus.pscore = '0;
    bus.pwin   = '0;
    bus.dwin   = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      bus.pscore[i*4 +: 4] = psc[i];
      bus.pwin[i]          = done_q && (psc[i] >= dsc);
      bus.dwin[i]          = done_q && (dsc >= psc[i]);
    end
  end

  assign bus.dscore     = dsc;
  assign bus.card_req   = adv & dealing;
  assign bus.load_pcard = pstb;
  assign bus.load_dcard = dstb;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_baccarat_table_ctrl.sv
// Bench for baccarat_table_ctrl: directed table scenarios plus random rounds scored by a rule model.
module tb_baccarat_table_ctrl;
  localparam int unsigned NP = 2;
  localparam int unsigned AP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   d3_cnt = 0;

  baccarat_table_if #(.NUM_PLAYERS(NP)) bus ();

  baccarat_table_ctrl #(.NUM_PLAYERS(NP), .AUTO_PERIOD(AP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.load_dcard[2]) d3_cnt++;

  int          pool [16];
  int          exp_slots [$];
  int          exp_ps [NP];
  int          exp_ds;
  logic [31:0] exp_pscore, exp_pwin, exp_dwin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int cval(int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  // Plays one round straight from the table rules, consuming pool[] in deal order.
  task automatic model_round();
    int n = 0;
    int psum [NP];
    int dsum = 0;
    bit drew [NP];
    int p3 = 0;
    int bs;
    bit bdraw;
    exp_slots.delete();
    for (int i = 0; i < NP; i++) begin psum[i] = 0; drew[i] = 0; end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) begin
        psum[i] += cval(pool[n]); n++;
        exp_slots.push_back(1 << (i*3 + k));
      end
      dsum += cval(pool[n]); n++;
      exp_slots.push_back(1 << (NP*3 + k));
    end
    if (dsum % 10 < 8) begin
      for (int i = 0; i < NP; i++) begin
        if (psum[i] % 10 <= 5) begin
          drew[i] = 1;
          if (i == 0) p3 = cval(pool[n]);
          psum[i] += cval(pool[n]); n++;
          exp_slots.push_back(1 << (i*3 + 2));
        end
      end
      bs = dsum % 10;
      if (!drew[0]) bdraw = (bs <= 5);
      else case (bs)
        0, 1, 2: bdraw = 1;
        3:       bdraw = (p3 != 8);
        4:       bdraw = p3 inside {[2:7]};
        5:       bdraw = p3 inside {[4:7]};
        6:       bdraw = p3 inside {[6:7]};
        default: bdraw = 0;
      endcase
      if (bdraw) begin
        dsum += cval(pool[n]); n++;
        exp_slots.push_back(1 << (NP*3 + 2));
      end
    end
    exp_ds = dsum % 10;
    exp_pscore = '0; exp_pwin = '0; exp_dwin = '0;
    for (int i = 0; i < NP; i++) begin
      exp_ps[i] = psum[i] % 10;
      exp_pscore |= 32'(exp_ps[i]) << (4*i);
      exp_pwin[i] = exp_ps[i] >= exp_ds;
      exp_dwin[i] = exp_ds >= exp_ps[i];
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.load_dcard, bus.load_pcard});
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; bus.step = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic idle_cycle(input string tag, input int slot);
    @(negedge clk);
    check({tag, "_idle_strobe"}, strobes(), 32'(slot));
    check({tag, "_idle_req"}, 32'(bus.card_req), 0);
  endtask

  task automatic do_step(input string tag, input int card, input int slot);
    @(negedge clk);
    check({tag, "_strobe"}, strobes(), 32'(slot));
    bus.step = 1'b1; bus.new_card = 4'(card);
    #1 check({tag, "_req"}, 32'(bus.card_req), 1);
    @(posedge clk); #1 bus.step = 1'b0; bus.new_card = 4'($urandom_range(0, 15));
  endtask

  task automatic eval_cycle(input string tag, input bit poke);
    @(negedge clk);
    check({tag, "_eval_strobe"}, strobes(), 0);
    bus.step = poke;
    #1 check({tag, "_eval_req"}, 32'(bus.card_req), 0);
    check({tag, "_eval_done"}, 32'(bus.done), 0);
    @(posedge clk); #1 bus.step = 1'b0;
  endtask

  task automatic check_final(input string tag);
    check({tag, "_pscore"}, 32'(bus.pscore), exp_pscore);
    check({tag, "_dscore"}, 32'(bus.dscore), 32'(exp_ds));
    check({tag, "_pwin"}, 32'(bus.pwin), exp_pwin);
    check({tag, "_dwin"}, 32'(bus.dwin), exp_dwin);
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_strobe_off"}, strobes(), 0);
    check({tag, "_req_off"}, 32'(bus.card_req), 0);
  endtask

  task automatic run_round(input string tag, input bit poke);
    model_round();
    do_reset();
    for (int s = 0; s < exp_slots.size(); s++) begin
      if ($urandom_range(0, 2) == 0) idle_cycle(tag, exp_slots[s]);
      do_step(tag, pool[s], exp_slots[s]);
      if (s == 2*NP + 1) eval_cycle(tag, poke);
    end
    @(negedge clk);
    check_final(tag);
  endtask

  initial begin
    int d3_before;
    bus.step = 1'b0;
    bus.new_card = 4'd0;

    // Reset state
    do_reset();
    #1;
    check("rst_pcard", 32'(bus.load_pcard), 32'h01);
    check("rst_dcard", 32'(bus.load_dcard), 0);
    check("rst_pscore", 32'(bus.pscore), 0);
    check("rst_dscore", 32'(bus.dscore), 0);
    check("rst_pwin", 32'(bus.pwin), 0);
    check("rst_dwin", 32'(bus.dwin), 0);
    check("rst_done", 32'(bus.done), 0);

`ifdef BACCARAT_AUTO_DEAL_EN
    // Auto-deal cadence with step held low
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      check("auto_req", 32'(bus.card_req), (k % AP == 0) ? 1 : 0);
    end
`else
    // Player natural stands, player 1 and banker draw
    pool = '{4, 2, 3, 5, 1, 2, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    run_round("nat_p", 1'b0);
    check("nat_p_steps", 32'(exp_slots.size()), 8);
    check("nat_p_lit_ps", 32'(bus.pscore), 32'h39);
    check("nat_p_lit_ds", 32'(bus.dscore), 6);
    check("nat_p_lit_pw", 32'(bus.pwin), 32'b01);
    check("nat_p_lit_dw", 32'(bus.dwin), 32'b10);

    // Step pulses in DONE are ignored
    for (int r = 0; r < 5; r++) begin
      @(negedge clk); bus.step = 1'b1; bus.new_card = 4'($urandom_range(1, 9));
      #1 check("hold_req", 32'(bus.card_req), 0);
      @(posedge clk); #1 bus.step = 1'b0;
      @(negedge clk);
      check_final("hold");
    end

    // Banker natural ends after EVAL
    d3_before = d3_cnt;
    pool = '{3, 9, 4, 3, 9, 4, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0};
    run_round("nat_d", 1'b1);
    #1 check("nat_d_no_d3", 32'(d3_cnt - d3_before), 0);
    check("nat_d_lit_pw", 32'(bus.pwin), 32'b10);
    check("nat_d_lit_dw", 32'(bus.dwin), 32'b11);

    // Banker 3 stands against p3 = 8
    d3_before = d3_cnt;
    pool = '{2, 10, 1, 2, 8, 2, 8, 5, 5, 0, 0, 0, 0, 0, 0, 0};
    run_round("tbl", 1'b0);
    #1 check("tbl_no_d3", 32'(d3_cnt - d3_before), 0);
    check("tbl_lit_ps", 32'(bus.pscore), 32'h82);
    check("tbl_lit_ds", 32'(bus.dscore), 3);
    check("tbl_lit_pw", 32'(bus.pwin), 32'b10);
    check("tbl_lit_dw", 32'(bus.dwin), 32'b01);

    // Reset with step high mid-deal
    do_reset();
    do_step("mid", 7, 1 << 0);
    do_step("mid", 8, 1 << 3);
    do_step("mid", 9, 1 << (NP*3));
    @(negedge clk); reset = 1'b1; bus.step = 1'b1; bus.new_card = 4'd5;
    @(negedge clk); reset = 1'b0; bus.step = 1'b0;
    check("mid_pcard", 32'(bus.load_pcard), 32'h01);
    check("mid_dcard", 32'(bus.load_dcard), 0);
    check("mid_pscore", 32'(bus.pscore), 0);
    check("mid_dscore", 32'(bus.dscore), 0);
    check("mid_done", 32'(bus.done), 0);
    do_step("mid_after", 4, 1 << 0);
    @(negedge clk);
    check("mid_after_ps", 32'(bus.pscore), 32'h04);
    check("mid_after_ds", 32'(bus.dscore), 0);
    check("mid_after_strobe", strobes(), 32'(1 << 3));

    // Random rounds, ranks include the out-of-range codes 0, 14 and 15
    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < 16; j++) pool[j] = $urandom_range(0, 15);
      run_round("rand", 1'($urandom_range(0, 1)));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
